// File: rtl/frame_serialiser.sv
`timescale 1ns/1ps
// Serialises 128-bit frames into 16 little-endian bytes over a valid/ready byte
// stream, inserting a FF FF FF 7F sync sequence after SYNC_GAP idle cycles.
module frame_serialiser #(
  parameter int unsigned SYNC_GAP = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] Frame,
  input  logic         FrameReady,
  output logic         FrameNext,
  output logic [7:0]   DataOut,
  output logic         DataValid,
  input  logic         DataReady,
  output logic         Busy,
  output logic [15:0]  FrameCount
);

  localparam int unsigned IDLE_W = (SYNC_GAP > 2) ? $clog2(SYNC_GAP) : 1;
  localparam logic [IDLE_W-1:0] SYNC_LAST = IDLE_W'((SYNC_GAP == 0) ? 0 : SYNC_GAP - 1);
  localparam bit SYNC_EN = (SYNC_GAP != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    SYNC = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [127:0]        shift_q, shift_d;
  logic [3:0]          idx_q, idx_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic                next_q, next_d;
  logic [15:0]         count_q, count_d;
  logic                armed_q;
  logic                xfer;

  assign DataValid  = (state_q != IDLE);
  assign Busy       = (state_q != IDLE);
  assign FrameNext  = next_q;
  assign FrameCount = count_q;
  assign xfer       = DataValid && DataReady;

  always_comb begin
    DataOut = 8'h00;
    case (state_q)
      SEND:    DataOut = shift_q[7:0];
      SYNC:    DataOut = (idx_q == 4'd3) ? 8'h7F : 8'hFF;
      default: DataOut = 8'h00;
    endcase
  end

  // NOTE: every always_comb target gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    idle_d  = idle_q;
    next_d  = 1'b0;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        // armed_q holds off the first cycle after reset release.
        if (armed_q) begin
          if (FrameReady) begin
            state_d = SEND;
            shift_d = Frame;
            idx_d   = 4'd0;
            idle_d  = '0;
            next_d  = 1'b1;
          end else if (SYNC_EN && (idle_q == SYNC_LAST)) begin
            state_d = SYNC;
            idx_d   = 4'd0;
            idle_d  = '0;
          end else if (idle_q != '1) begin
            idle_d = idle_q + 1'b1;
          end
        end
      end
      SEND: begin
        if (xfer) begin
          shift_d = {8'h00, shift_q[127:8]};
          idx_d   = idx_q + 4'd1;
          if (idx_q == 4'd15) begin
            state_d = IDLE;
            count_d = count_q + 16'd1;
          end
        end
      end
      SYNC: begin
        if (xfer) begin
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd3) begin
            state_d = IDLE;
            idx_d   = 4'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  // NOTE: the shift register is reset too, so DataOut and any aborted frame
  // contents are deterministic after reset rather than left from the last frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= 4'd0;
      idle_q  <= '0;
      next_q  <= 1'b0;
      count_q <= 16'd0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      idle_q  <= idle_d;
      next_q  <= next_d;
      count_q <= count_d;
      armed_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_frame_serialiser.sv
`timescale 1ns/1ps
// Directed bench for frame_serialiser with SYNC_GAP=8: frame send, backpressure,
// sync insertion, collisions, FrameCount wrap and asynchronous reset abort.
module tb_frame_serialiser;

  logic         clk;
  logic         rst_n;
  logic [127:0] frame;
  logic         frame_ready;
  logic         frame_next;
  logic [7:0]   data_out;
  logic         data_valid;
  logic         data_ready;
  logic         busy;
  logic [15:0]  frame_count;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [127:0] FRM_A = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] FRM_B = 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0;
  localparam logic [127:0] FRM_C = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] FRM_D = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] FRM_E = 128'hDEADBEEFCAFEF00D5A5AA5A5C3C33C3C;
  localparam logic [127:0] FRM_F = 128'h8877665544332211F0E1D2C3B4A59687;

  frame_serialiser #(.SYNC_GAP(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Frame      (frame),
    .FrameReady (frame_ready),
    .FrameNext  (frame_next),
    .DataOut    (data_out),
    .DataValid  (data_valid),
    .DataReady  (data_ready),
    .Busy       (busy),
    .FrameCount (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fr;
    logic        dr;
    logic        nxt;
    logic        vld;
    logic [7:0]  data;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Packs {FrameNext, Busy, DataValid, DataOut, FrameCount}; Busy tracks DataValid.
  task automatic check_out(input string name, input logic nxt, input logic vld,
                           input logic [7:0] d, input logic [15:0] c);
    logic [31:0] act, exp;
    act = {5'd0, frame_next, busy, data_valid, data_out, frame_count};
    exp = {5'd0, nxt, vld, vld, d, c};
    check(name, act, exp);
  endtask

  task automatic send_bytes(input string name, input logic [127:0] f,
                            input logic [15:0] cnt, input int nbytes);
    for (int n = 0; n < nbytes; n++) begin
      @(negedge clk);
      check_out(name, (n == 0), 1'b1, f[8*n +: 8], cnt);
      frame_ready = 1'b0;
      data_ready  = 1'b1;
    end
  endtask

  task automatic idle_gap(input string name, input int ncyc, input logic [15:0] cnt);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      check_out(name, 1'b0, 1'b0, 8'h00, cnt);
      frame_ready = 1'b0;
      data_ready  = 1'b1;
    end
  endtask

  task automatic sync_seq(input string name, input logic [15:0] cnt,
                          input bit stall, input bit frame_mid);
    logic [7:0] sb [4];
    sb = '{8'hFF, 8'hFF, 8'hFF, 8'h7F};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_out(name, 1'b0, 1'b1, sb[k], cnt);
      data_ready = 1'b1;
      if (frame_mid && k == 1) begin
        frame       = FRM_C;
        frame_ready = 1'b1;
      end
      if (stall && k == 1) begin
        data_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check_out({name, "_stall"}, 1'b0, 1'b1, sb[k], cnt);
        end
        data_ready = 1'b1;
      end
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    frame       = FRM_A;
    frame_ready = 1'b1;
    data_ready  = 1'b1;

    // Reset values held while rst_n=0, even with FrameReady asserted.
    repeat (2) @(negedge clk);
    check_out("reset_hold", 1'b0, 1'b0, 8'h00, 16'h0000);

    // Single frame: row 0 is the held-off first cycle after release.
    vecs[0] = '{fr: 1'b1, dr: 1'b1, nxt: 1'b0, vld: 1'b0, data: 8'h00, cnt: 16'd0};
    for (int n = 0; n < 16; n++)
      vecs[n+1] = '{fr: (n < 15), dr: 1'b1, nxt: (n == 0), vld: 1'b1,
                    data: 8'(n), cnt: 16'd0};
    vecs[17] = '{fr: 1'b0, dr: 1'b1, nxt: 1'b0, vld: 1'b0, data: 8'h00, cnt: 16'd1};

    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 18; r++) begin
      @(negedge clk);
      check_out($sformatf("single_row%0d", r), vecs[r].nxt, vecs[r].vld,
                vecs[r].data, vecs[r].cnt);
      frame_ready = vecs[r].fr;
      data_ready  = vecs[r].dr;
    end

    // Backpressure: DataReady alternates 0/1, each byte held two cycles.
    @(negedge clk);
    frame       = FRM_B;
    frame_ready = 1'b1;
    data_ready  = 1'b0;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      check_out($sformatf("bp_cyc%0d", c), (c == 0), 1'b1, 8'hA0 + 8'(c / 2), 16'd1);
      frame_ready = 1'b0;
      data_ready  = (c % 2 == 1);
    end

    // Sync: 8 idle cycles, FF FF FF 7F (stalled mid-way), then again.
    idle_gap("gap1", 8, 16'd2);
    sync_seq("sync1", 16'd2, 1'b1, 1'b0);
    idle_gap("gap2", 8, 16'd2);
    // A frame presented during SYNC waits until 0x7F has gone.
    sync_seq("sync2", 16'd2, 1'b0, 1'b1);
    @(negedge clk);
    check_out("frame_waits_sync", 1'b0, 1'b0, 8'h00, 16'd2);
    send_bytes("frame_c", FRM_C, 16'd2, 16);

    // Collision: FrameReady rises on the threshold cycle, frame wins.
    idle_gap("gap3", 8, 16'd3);
    frame       = FRM_D;
    frame_ready = 1'b1;
    send_bytes("collide_d", FRM_D, 16'd3, 16);

    @(negedge clk);
    check_out("after_d", 1'b0, 1'b0, 8'h00, 16'd4);
    force dut.count_q = 16'hFFFF;
    #1;
    release dut.count_q;
    frame       = FRM_E;
    frame_ready = 1'b1;
    send_bytes("frame_e", FRM_E, 16'hFFFF, 16);
    @(negedge clk);
    check_out("count_wrap", 1'b0, 1'b0, 8'h00, 16'h0000);

    // Asynchronous reset while byte 7 of the next frame is presented.
    frame       = FRM_F;
    frame_ready = 1'b1;
    send_bytes("frame_f", FRM_F, 16'h0000, 8);
    rst_n = 1'b0;
    #1;
    check_out("async_abort", 1'b0, 1'b0, 8'h00, 16'h0000);
    @(negedge clk);
    check_out("abort_hold", 1'b0, 1'b0, 8'h00, 16'h0000);

    // After release, FrameReady is ignored for one full cycle.
    rst_n       = 1'b1;
    frame_ready = 1'b1;
    @(negedge clk);
    check_out("post_reset_wait", 1'b0, 1'b0, 8'h00, 16'h0000);
    @(negedge clk);
    check_out("post_reset_frame", 1'b1, 1'b1, FRM_F[7:0], 16'h0000);
    frame_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
